hist_acq_scheduler: RTL and testbench
=====================================

Name: hist_acq_scheduler

Overview:
- Acquisition sequencer placed in front of hisBuilderFSM. It collects TDC hits from all pixel lanes in parallel during a fixed time window.
- After the window closes, it serializes the captured hits into the builder's single wrEn/data stream in pixel-major, sample-minor order.
- It repeats this for ACQ_NUM acquisitions, then signals completion so the builder's peakResult can be read.

Parameters:
- NP, 10, timestamp width (matches builder `Np).
- PIXEL_NUM, 3, number of pixel lanes.
- SAMPLES, 2, timestamp slots per pixel per acquisition.
- ACQ_NUM, 2, acquisitions per frame.
- WINDOW_CYCLES, 8, length of the COLLECT window in clocks (≥1).
- GAP_CYCLES, 4, idle clocks between acquisitions (≥1).

Ports:
- clk  in  1  system clock.
- res  in  1  asynchronous active-low reset.
- start  in  1  one-cycle frame start request; acted on only in IDLE.
- abort  in  1  frame abort; effective from any state.
- hit_valid  in  PIXEL_NUM  per-lane hit strobe.
- hit_ts  in  PIXEL_NUM*NP  per-lane timestamp; lane p occupies bits [p*NP +: NP].
- wr_en  out  1  write strobe to the builder (its wrEn).
- wr_data  out  NP  write data to the builder (its data).
- busy  out  1  high in every state except IDLE.
- acq_cnt  out  clog2(ACQ_NUM)+1  index of the current acquisition.
- frame_done  out  1  one-cycle pulse at frame end.
- hit_drop  out  1  sticky flag: a hit was lost because its pixel's slots were full.

Behaviour:
- Reset (res=0, asynchronous): state IDLE; wr_en=0, wr_data=0, busy=0, acq_cnt=0, frame_done=0, hit_drop=0; all slots cleared to NO_HIT. NO_HIT is all-ones (1023 at NP=10).
- All outputs are registered.
- IDLE:
  - start=1 and abort=0 → COLLECT next cycle.
  - On that transition: window counter=0, acq_cnt=0, hit_drop cleared.
- COLLECT:
  - Lasts exactly WINDOW_CYCLES cycles.
  - Each cycle, for each lane p with hit_valid[p]=1: the timestamp is written into p's next free slot, filling slots 0..SAMPLES-1 in order.
  - Any number of lanes may hit in the same cycle; all are accepted.
  - A hit arriving when all of p's slots are full is discarded and sets hit_drop.
  - A hit on the last window cycle is captured.
  - After the last window cycle → DRAIN.
- DRAIN:
  - Lasts PIXEL_NUM*SAMPLES cycles, with wr_en=1 on every cycle.
  - Word k carries pixel k/SAMPLES, slot k%SAMPLES; empty slots emit NO_HIT.
  - The first wr_en is the cycle after the last COLLECT cycle.
  - hit_valid is ignored here and in every non-COLLECT state; this never sets hit_drop.
  - After the last word: slots cleared to NO_HIT, then go to GAP.
- GAP:
  - wr_en=0 for GAP_CYCLES cycles.
  - Then, if acq_cnt==ACQ_NUM-1 → DONE. Otherwise acq_cnt+1 and → COLLECT.
- DONE: frame_done=1 for one cycle, then → IDLE. acq_cnt holds its final value until the next start.
- Outside DRAIN, wr_en=0 and wr_data=0.
- start while busy is ignored.
- abort=1 in any state:
  - Next cycle: state=IDLE, wr_en=0, slots cleared, acq_cnt=0.
  - No frame_done pulse; hit_drop keeps its value.
  - abort wins over a simultaneous start.
- Counters: window, drain and gap counters saturate at their terminal values and are reset on every state entry.

Decomposition:
- Package hist_sched_pkg holds:
  - the state enum {IDLE, COLLECT, DRAIN, GAP, DONE};
  - the NO_HIT constant function (all-ones of width NP);
  - the lane slice helper.
- One sub-module, hit_slot_buf, instantiated per pixel:
  - SAMPLES×NP slot registers plus a fill counter;
  - capture, clear and full outputs;
  - a read mux indexed by slot.
- The top level holds the FSM, counters and output mux.

Test Plan:
- Defaults. start; hits: lane0 ts=108 in window cycle 0 and ts=511 in cycle 3; lane1 ts=1022 in cycle 2; lane2 none. → DRAIN emits 108, 511, 1022, 1023, 1023, 1023 on 6 consecutive wr_en cycles. The first wr_en is cycle 9 after the start edge.
- Same-cycle hits: lanes 0/1/2 hit in the same cycle with ts 300/50/48. → All three are captured; DRAIN emits 300, 1023, 50, 1023, 48, 1023.
- Overflow: lane0 gets 3 hits (1, 2, 3). → Emits 1 and 2; hit_drop=1 and stays 1 through frame end; it clears on the next start.
- Full frame, ACQ_NUM=2. → Two 6-word bursts separated by exactly 4 wr_en=0 cycles and an 8-cycle window. acq_cnt goes 0 then 1. frame_done pulses once; busy falls the cycle after that.
- abort in the 3rd DRAIN cycle. → wr_en=0 next cycle; IDLE; acq_cnt=0; no frame_done. A following start produces an all-NO_HIT burst if no hits arrive.
- Asynchronous reset mid-COLLECT. → All outputs go to 0 immediately, without waiting for a clock edge. After res rises, the block stays IDLE until start.

Source files
------------

// File: rtl/hist_sched_pkg.sv
// ----------------------------------------------------------------------------
// hist_sched_pkg
// Shared types and helpers for the histogram acquisition scheduler.
//   schedState_e : scheduler FSM states
//   noHit()      : value stored in an empty timestamp slot (all-ones of np bits)
//   laneLsb()    : LSB position of a lane inside a flattened per-lane bus
// ----------------------------------------------------------------------------
package hist_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        DRAIN,
        GAP,
        DONE
    } schedState_e;

    // Returned 32 bits wide; callers size-cast to their own timestamp width.
    function automatic logic [31:0] noHit(input int np);
        if (np >= 32) begin
            return '1;
        end
        return (32'd1 << np) - 32'd1;
    endfunction

    function automatic int laneLsb(input int lane, input int np);
        return lane * np;
    endfunction

endpackage

// File: rtl/hit_slot_buf.sv
// ----------------------------------------------------------------------------
// hit_slot_buf
// Per-pixel timestamp store: SAMPLES slots filled in order 0..SAMPLES-1.
// Ports:
//   clk, res        clock, asynchronous active-low reset (slots -> NO_HIT)
//   capture         store ts into the next free slot (ignored when full)
//   clear           empty all slots back to NO_HIT (wins over capture)
//   ts [NP]         timestamp to store
//   rdSel [SLOT_W]  slot to read
//   rdData [NP]     selected slot, forwarding a same-cycle capture into it
//   full            every slot is occupied
// ----------------------------------------------------------------------------
module hit_slot_buf
    import hist_sched_pkg::*;
#(
    parameter  int NP      = 10,
    parameter  int SAMPLES = 2,
    localparam int SLOT_W  = (SAMPLES > 1) ? $clog2(SAMPLES) : 1
) (
    input  logic              clk,
    input  logic              res,
    input  logic              capture,
    input  logic              clear,
    input  logic [NP-1:0]     ts,
    input  logic [SLOT_W-1:0] rdSel,
    output logic [NP-1:0]     rdData,
    output logic              full
);

    localparam int            FILL_W = $clog2(SAMPLES + 1);
    localparam logic [NP-1:0] NO_HIT = NP'(noHit(NP));

    logic [NP-1:0]     slotQ [SAMPLES];
    logic [FILL_W-1:0] fillCnt;

    assign full = (fillCnt == FILL_W'(SAMPLES));

    // NOTE: the slot array is reset, not just the fill counter -- an empty
    // slot must read back as NO_HIT, so its contents are architectural.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            for (int s = 0; s < SAMPLES; s++) begin
                slotQ[s] <= NO_HIT;
            end
            fillCnt <= '0;
        end else if (clear) begin
            for (int s = 0; s < SAMPLES; s++) begin
                slotQ[s] <= NO_HIT;
            end
            fillCnt <= '0;
        end else if (capture && !full) begin
            for (int s = 0; s < SAMPLES; s++) begin
                if (fillCnt == FILL_W'(s)) begin
                    slotQ[s] <= ts;
                end
            end
            fillCnt <= fillCnt + 1'b1;
        end
    end

    // The first drain word is registered on the same edge that captures the
    // last window hit, so a capture into the slot being read is forwarded.
    // NOTE: rdData is defaulted before the loop so no path leaves it unassigned
    // (otherwise a latch is inferred).
    always_comb begin
        rdData = NO_HIT;
        for (int s = 0; s < SAMPLES; s++) begin
            if (rdSel == SLOT_W'(s)) begin
                rdData = (capture && fillCnt == FILL_W'(s)) ? ts : slotQ[s];
            end
        end
    end

endmodule

// File: rtl/hist_acq_scheduler.sv
// ----------------------------------------------------------------------------
// hist_acq_scheduler
// Collects per-lane TDC hits during a fixed window, then serialises them
// pixel-major / sample-minor into the histogram builder's write stream,
// ACQ_NUM times per frame.
// Ports:
//   clk, res              clock, asynchronous active-low reset
//   start                 frame start request (IDLE only)
//   abort                 return to IDLE from any state, no frame_done
//   hit_valid [PIXEL_NUM] per-lane hit strobe (used only in COLLECT)
//   hit_ts [PIXEL_NUM*NP] per-lane timestamps, lane p at [p*NP +: NP]
//   wr_en, wr_data [NP]   builder write strobe / data (DRAIN only)
//   busy                  any state other than IDLE
//   acq_cnt               current acquisition index
//   frame_done            one-cycle pulse in DONE
//   hit_drop              sticky: a hit found its pixel's slots full
// All outputs are registered from the next-state value, so they line up
// with the state they describe.
// ----------------------------------------------------------------------------
module hist_acq_scheduler
    import hist_sched_pkg::*;
#(
    parameter int NP            = 10,
    parameter int PIXEL_NUM     = 3,
    parameter int SAMPLES       = 2,
    parameter int ACQ_NUM       = 2,
    parameter int WINDOW_CYCLES = 8,
    parameter int GAP_CYCLES    = 4
) (
    input  logic                          clk,
    input  logic                          res,
    input  logic                          start,
    input  logic                          abort,
    input  logic [PIXEL_NUM-1:0]          hit_valid,
    input  logic [PIXEL_NUM*NP-1:0]       hit_ts,
    output logic                          wr_en,
    output logic [NP-1:0]                 wr_data,
    output logic                          busy,
    output logic [$clog2(ACQ_NUM):0]      acq_cnt,
    output logic                          frame_done,
    output logic                          hit_drop
);

    localparam int WORDS  = PIXEL_NUM * SAMPLES;
    localparam int ACQ_W  = $clog2(ACQ_NUM) + 1;
    localparam int WIN_W  = $clog2(WINDOW_CYCLES + 1);
    localparam int DRN_W  = $clog2(WORDS + 1);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
    localparam int SLOT_W = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;

    localparam logic [NP-1:0]    NO_HIT   = NP'(noHit(NP));
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(WORDS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [ACQ_W-1:0] ACQ_LAST = ACQ_W'(ACQ_NUM - 1);

    schedState_e       state, nextState;
    logic [WIN_W-1:0]  winCnt;
    logic [DRN_W-1:0]  drainCnt;
    logic [GAP_W-1:0]  gapCnt;
    logic [ACQ_W-1:0]  acqCnt;

    logic              wrEnQ, busyQ, frameDoneQ, hitDropQ;
    logic [NP-1:0]     wrDataQ;

    logic [PIXEL_NUM-1:0] laneCapture, laneFull;
    logic [NP-1:0]        laneRd [PIXEL_NUM];
    logic                 slotClear, dropNow, frameStart;
    logic [SLOT_W-1:0]    rdSlot;
    logic [NP-1:0]        drainData;
    int                   wordIdx, rdPix;

    // ------------------------------------------------------------------
    // Slot buffers, one per pixel lane
    // ------------------------------------------------------------------
    for (genvar p = 0; p < PIXEL_NUM; p++) begin : gLane
        assign laneCapture[p] = (state == COLLECT) && hit_valid[p] && !abort;

        hit_slot_buf #(
            .NP      (NP),
            .SAMPLES (SAMPLES)
        ) uBuf (
            .clk     (clk),
            .res     (res),
            .capture (laneCapture[p]),
            .clear   (slotClear),
            .ts      (hit_ts[laneLsb(p, NP) +: NP]),
            .rdSel   (rdSlot),
            .rdData  (laneRd[p]),
            .full    (laneFull[p])
        );
    end

    assign slotClear  = abort || (state == DRAIN && drainCnt == DRN_LAST);
    assign dropNow    = (state == COLLECT) && !abort && |(hit_valid & laneFull);
    assign frameStart = (state == IDLE) && (nextState == COLLECT);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = COLLECT;
            COLLECT: if (winCnt == WIN_LAST) nextState = DRAIN;
            DRAIN:   if (drainCnt == DRN_LAST) nextState = GAP;
            GAP: begin
                if (gapCnt == GAP_LAST) begin
                    nextState = (acqCnt == ACQ_LAST) ? DONE : COLLECT;
                end
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
        if (abort) begin
            nextState = IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Drain read pointer: the word that will be on wr_data after this edge
    // (word 0 on DRAIN entry, then one ahead of the current drain count).
    // ------------------------------------------------------------------
    always_comb begin
        wordIdx   = (state == DRAIN) ? int'(drainCnt) + 1 : 0;
        rdPix     = wordIdx / SAMPLES;
        rdSlot    = SLOT_W'(wordIdx % SAMPLES);
        drainData = NO_HIT;
        for (int p = 0; p < PIXEL_NUM; p++) begin
            if (p == rdPix) begin
                drainData = laneRd[p];
            end
        end
    end

    // ------------------------------------------------------------------
    // State, counters and registered outputs
    // ------------------------------------------------------------------
    // NOTE: every register here uses non-blocking assignment so all of them
    // sample pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Each counter restarts when its state is entered and saturates at its
    // terminal value while the state is held.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            winCnt   <= '0;
            drainCnt <= '0;
            gapCnt   <= '0;
        end else begin
            if (nextState == COLLECT && state != COLLECT) begin
                winCnt <= '0;
            end else if (state == COLLECT && winCnt != WIN_LAST) begin
                winCnt <= winCnt + 1'b1;
            end

            if (nextState == DRAIN && state != DRAIN) begin
                drainCnt <= '0;
            end else if (state == DRAIN && drainCnt != DRN_LAST) begin
                drainCnt <= drainCnt + 1'b1;
            end

            if (nextState == GAP && state != GAP) begin
                gapCnt <= '0;
            end else if (state == GAP && gapCnt != GAP_LAST) begin
                gapCnt <= gapCnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            acqCnt     <= '0;
            hitDropQ   <= 1'b0;
            wrEnQ      <= 1'b0;
            wrDataQ    <= '0;
            busyQ      <= 1'b0;
            frameDoneQ <= 1'b0;
        end else begin
            if (abort || frameStart) begin
                acqCnt <= '0;
            end else if (state == GAP && nextState == COLLECT) begin
                acqCnt <= acqCnt + 1'b1;
            end

            if (frameStart) begin
                hitDropQ <= 1'b0;
            end else if (dropNow) begin
                hitDropQ <= 1'b1;
            end

            wrEnQ      <= (nextState == DRAIN);
            wrDataQ    <= (nextState == DRAIN) ? drainData : '0;
            busyQ      <= (nextState != IDLE);
            frameDoneQ <= (nextState == DONE);
        end
    end

    assign wr_en      = wrEnQ;
    assign wr_data    = wrDataQ;
    assign busy       = busyQ;
    assign acq_cnt    = acqCnt;
    assign frame_done = frameDoneQ;
    assign hit_drop   = hitDropQ;

endmodule

// File: tb/tb_hist_acq_scheduler.sv
// ----------------------------------------------------------------------------
// tb_hist_acq_scheduler
// Directed and randomised frames against a timeline model: the expected
// output on every cycle is derived from the cycle's offset inside the frame
// and from per-acquisition slot contents built from the hit schedule.
// ----------------------------------------------------------------------------
module tb_hist_acq_scheduler;

    localparam int NP     = 10;
    localparam int P      = 3;
    localparam int S      = 2;
    localparam int ACQ    = 2;
    localparam int W      = 8;
    localparam int G      = 4;
    localparam int D      = P * S;
    localparam int PER    = W + D + G;
    localparam int DONE_E = ACQ * PER;
    localparam int T      = DONE_E + 1;
    localparam int TSW    = P * NP;
    localparam logic [NP-1:0] NOHIT = '1;

    logic           clk = 1'b0;
    logic           res = 1'b0;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic [P-1:0]   hitValid = '0;
    logic [TSW-1:0] hitTs = '0;
    logic           wrEn, busy, frameDone, hitDrop;
    logic [NP-1:0]  wrData;
    logic [1:0]     acqCnt;

    hist_acq_scheduler #(
        .NP(NP), .PIXEL_NUM(P), .SAMPLES(S), .ACQ_NUM(ACQ),
        .WINDOW_CYCLES(W), .GAP_CYCLES(G)
    ) dut (
        .clk        (clk),
        .res        (res),
        .start      (start),
        .abort      (abort),
        .hit_valid  (hitValid),
        .hit_ts     (hitTs),
        .wr_en      (wrEn),
        .wr_data    (wrData),
        .busy       (busy),
        .acq_cnt    (acqCnt),
        .frame_done (frameDone),
        .hit_drop   (hitDrop)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Hit schedule per acquisition / window cycle / lane
    bit            sV  [ACQ][W][P];
    logic [NP-1:0] sTs [ACQ][W][P];

    // Reference state: slot contents of the current acquisition, drop flag
    logic [NP-1:0] mSlot [P][S];
    int            mCnt  [P];
    bit            mDrop;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearSched();
        for (int a = 0; a < ACQ; a++)
            for (int c = 0; c < W; c++)
                for (int p = 0; p < P; p++) begin
                    sV[a][c][p]  = 1'b0;
                    sTs[a][c][p] = '0;
                end
    endtask

    task automatic randSched(input int pct);
        for (int a = 0; a < ACQ; a++)
            for (int c = 0; c < W; c++)
                for (int p = 0; p < P; p++) begin
                    sV[a][c][p]  = ($urandom_range(0, 99) < pct);
                    sTs[a][c][p] = NP'($urandom_range(0, 1023));
                end
    endtask

    task automatic checkIdle(input string tag, input bit expDrop, input logic [1:0] expAcq);
        check({tag, ".wr_en"},      wrEn, 0);
        check({tag, ".wr_data"},    wrData, 0);
        check({tag, ".busy"},       busy, 0);
        check({tag, ".frame_done"}, frameDone, 0);
        check({tag, ".acq_cnt"},    acqCnt, expAcq);
        check({tag, ".hit_drop"},   hitDrop, expDrop);
    endtask

    // Runs one frame from IDLE. abortEdge >= 0 raises abort in the cycle
    // after that edge and checks the return to IDLE instead of finishing.
    task automatic runFrame(input string tag, input int abortEdge);
        int a, r, k;
        bit expWr;
        logic [NP-1:0] expData;
        start    = 1'b1;
        abort    = 1'b0;
        hitValid = P'($urandom);     // ignored: lanes are only sampled in COLLECT
        hitTs    = TSW'($urandom);
        tick();
        start = 1'b0;
        mDrop = 1'b0;
        for (int e = 0; e <= T; e++) begin
            if (e < DONE_E) begin
                a       = e / PER;
                r       = e % PER;
                expWr   = (r >= W) && (r < W + D);
                k       = r - W;
                expData = expWr ? mSlot[k / S][k % S] : '0;
                check($sformatf("%s.e%0d.busy", tag, e),   busy, 1);
                check($sformatf("%s.e%0d.wr_en", tag, e),  wrEn, expWr);
                check($sformatf("%s.e%0d.wr_data", tag, e), wrData, expData);
                check($sformatf("%s.e%0d.acq", tag, e),    acqCnt, a);
                check($sformatf("%s.e%0d.done", tag, e),   frameDone, 0);
            end else begin
                check($sformatf("%s.e%0d.busy", tag, e),  busy, (e == DONE_E));
                check($sformatf("%s.e%0d.wr_en", tag, e), wrEn, 0);
                check($sformatf("%s.e%0d.done", tag, e),  frameDone, (e == DONE_E));
                check($sformatf("%s.e%0d.acq", tag, e),   acqCnt, ACQ - 1);
            end
            check($sformatf("%s.e%0d.drop", tag, e), hitDrop, mDrop);
            if (e == T) break;

            if (e == abortEdge) begin
                abort    = 1'b1;
                hitValid = '0;
                tick();
                abort = 1'b0;
                checkIdle({tag, ".abort"}, mDrop, 2'd0);
                return;
            end

            // Inputs for the next edge; the state in force there is the one
            // just checked.
            hitValid = P'($urandom);
            hitTs    = TSW'($urandom);
            if (e < DONE_E && (e % PER) < W) begin
                a = e / PER;
                r = e % PER;
                if (r == 0) begin
                    for (int p = 0; p < P; p++) begin
                        mCnt[p] = 0;
                        for (int s = 0; s < S; s++) mSlot[p][s] = NOHIT;
                    end
                end
                for (int p = 0; p < P; p++) begin
                    hitValid[p]          = sV[a][r][p];
                    hitTs[p*NP +: NP]    = sTs[a][r][p];
                    if (sV[a][r][p]) begin
                        if (mCnt[p] < S) begin
                            mSlot[p][mCnt[p]] = sTs[a][r][p];
                            mCnt[p]++;
                        end else begin
                            mDrop = 1'b1;
                        end
                    end
                end
            end
            start = ($urandom_range(0, 3) == 0);   // ignored while busy
            tick();
        end
        start    = 1'b0;
        hitValid = '0;
    endtask

    initial begin
        // Reset state
        #12;
        checkIdle("reset", 1'b0, 2'd0);
        res = 1'b1;
        tick();
        checkIdle("postReset", 1'b0, 2'd0);

        // Frame A: sparse hits in acq0, same-cycle hits on the last window
        // cycle of acq1.
        clearSched();
        sV[0][0][0] = 1; sTs[0][0][0] = 10'd108;
        sV[0][3][0] = 1; sTs[0][3][0] = 10'd511;
        sV[0][2][1] = 1; sTs[0][2][1] = 10'd1022;
        sV[1][7][0] = 1; sTs[1][7][0] = 10'd300;
        sV[1][7][1] = 1; sTs[1][7][1] = 10'd50;
        sV[1][7][2] = 1; sTs[1][7][2] = 10'd48;
        runFrame("frameA", -1);
        checkIdle("frameA.end", 1'b0, 2'(ACQ - 1));

        // Frame B: lane0 overflow, hit_drop sticky through frame end
        clearSched();
        sV[0][0][0] = 1; sTs[0][0][0] = 10'd1;
        sV[0][1][0] = 1; sTs[0][1][0] = 10'd2;
        sV[0][5][0] = 1; sTs[0][5][0] = 10'd3;
        runFrame("overflow", -1);
        checkIdle("overflow.end", 1'b1, 2'(ACQ - 1));

        // Next start clears hit_drop (checked at the first frame cycle)
        randSched(20);
        runFrame("rand0", -1);
        checkIdle("rand0.end", mDrop, 2'(ACQ - 1));

        // Abort in the 3rd DRAIN cycle of the second acquisition
        randSched(40);
        runFrame("abort", PER + W + 2);
        for (int i = 0; i < 3; i++) begin
            hitValid = P'($urandom);
            tick();
            checkIdle($sformatf("abort.hold%0d", i), mDrop, 2'd0);
        end

        // abort wins over a simultaneous start
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        checkIdle("startAbort", mDrop, 2'd0);

        // After abort the slots are empty: an all-NO_HIT frame
        clearSched();
        runFrame("postAbort", -1);
        checkIdle("postAbort.end", 1'b0, 2'(ACQ - 1));

        // Random frames
        for (int f = 0; f < 4; f++) begin
            randSched(15 + 20 * f);
            runFrame($sformatf("rand%0d", f + 1), -1);
        end

        // Asynchronous reset in the middle of COLLECT
        start = 1'b1;
        tick();
        start    = 1'b0;
        hitValid = 3'b111;
        hitTs    = TSW'($urandom);
        tick();
        tick();
        hitValid = '0;
        #3 res = 1'b0;
        #1;
        check("asyncRst.wr_en", wrEn, 0);
        check("asyncRst.wr_data", wrData, 0);
        check("asyncRst.busy", busy, 0);
        check("asyncRst.acq", acqCnt, 0);
        check("asyncRst.done", frameDone, 0);
        check("asyncRst.drop", hitDrop, 0);
        #2;
        tick();
        tick();
        res = 1'b1;
        for (int i = 0; i < 5; i++) begin
            hitValid = P'($urandom);
            tick();
            checkIdle($sformatf("asyncRst.idle%0d", i), 1'b0, 2'd0);
        end
        hitValid = '0;

        // Slots were cleared by reset: an empty frame drains NO_HIT only
        clearSched();
        runFrame("postRst", -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
